// File: rtl/cache_2way_wb.sv
// 2-way set-associative write-back, write-allocate data cache with per-set LRU.
// Hits complete combinationally; misses write back a dirty victim, then refill a 128-bit line.
module cache_2way_wb #(
  parameter int ADDR_W  = 30,
  parameter int INDEX_W = 2
) (
  input  logic                clk,
  input  logic                proc_reset,
  input  logic                proc_read,
  input  logic                proc_write,
  input  logic [ADDR_W-1:0]   proc_addr,
  input  logic [31:0]         proc_wdata,
  output logic                proc_stall,
  output logic [31:0]         proc_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [127:0]        mem_wdata,
  input  logic [127:0]        mem_rdata,
  input  logic                mem_ready
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WB    = 2'd1;
  localparam logic [1:0] ALLOC = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  victim_q, victim_d;
  logic [SETS-1:0]       lru_q, lru_d;
  logic [1:0][SETS-1:0]  valid_q, valid_d;
  logic [1:0][SETS-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [2][SETS];
  logic [TAG_W-1:0]      tag_d  [2][SETS];
  logic [127:0]          line_q [2][SETS];
  logic [127:0]          line_d [2][SETS];
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_W-3:0]     mem_addr_q, mem_addr_d;
  logic [127:0]          mem_wdata_q, mem_wdata_d;

  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      req_tag;
  logic [1:0]            word;
  logic                  req;
  logic                  hit0, hit1, hit, hit_way;
  logic                  pick_way;
  logic [127:0]          hit_line;

  assign idx      = proc_addr[INDEX_W+1:2];
  assign req_tag  = proc_addr[ADDR_W-1:INDEX_W+2];
  assign word     = proc_addr[1:0];
  assign req      = proc_read | proc_write;
  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_line = line_q[hit_way][idx];

  // Fill an empty way first (way 0 before way 1); only evict the LRU way when the set is full.
  assign pick_way = !valid_q[0][idx] ? 1'b0 :
                    !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  assign proc_rdata = hit_line[{word, 5'd0} +: 32];
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    lru_d       = lru_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    line_d      = line_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    proc_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            lru_d[idx] = ~hit_way;
            if (proc_write) begin
              line_d[hit_way][idx][{word, 5'd0} +: 32] = proc_wdata;
              dirty_d[hit_way][idx] = 1'b1;
            end
          end else begin
            proc_stall = 1'b1;
            victim_d   = pick_way;
            if (valid_q[pick_way][idx] && dirty_q[pick_way][idx]) begin
              state_d     = WB;
              mem_write_d = 1'b1;
              mem_addr_d  = {tag_q[pick_way][idx], idx};
              mem_wdata_d = line_q[pick_way][idx];
            end else begin
              state_d    = ALLOC;
              mem_read_d = 1'b1;
              mem_addr_d = proc_addr[ADDR_W-1:2];
            end
          end
        end
      end
      WB: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          mem_write_d             = 1'b0;
          dirty_d[victim_q][idx]  = 1'b0;
          state_d                 = ALLOC;
          mem_read_d              = 1'b1;
          mem_addr_d              = proc_addr[ADDR_W-1:2];
        end
      end
      ALLOC: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          line_d[victim_q][idx]  = mem_rdata;
          tag_d[victim_q][idx]   = req_tag;
          valid_d[victim_q][idx] = 1'b1;
          dirty_d[victim_q][idx] = 1'b0;
          lru_d[idx]             = ~victim_q;
          mem_read_d             = 1'b0;
          state_d                = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line data and tags need no reset: a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    line_q <= line_d;
    tag_q  <= tag_d;
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      victim_q    <= 1'b0;
      lru_q       <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      lru_q       <= lru_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_cache_2way_wb.sv
// Scoreboard bench for cache_2way_wb: a recency-list cache model predicts memory traffic,
// read data and stall lengths; a monitor pops expectations as the DUT presents events.
module tb_cache_2way_wb;

  localparam int EV_MEMWR = 0;
  localparam int EV_MEMRD = 1;
  localparam int EV_RDATA = 2;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  cache_2way_wb #(.ADDR_W(30), .INDEX_W(2)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(proc_stall),
    .proc_rdata(proc_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    logic [27:0]  addr;
    logic [127:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  assertions = 0;
  int  failures   = 0;
  bit  drv_active = 1'b0;
  bit  hold_read  = 1'b0;
  int  mem_cycles = 0;

  // Reference model: each set is a recency list (index 0 = least recently used).
  logic [27:0]  set_lines [4][2];
  int           set_cnt   [4];
  logic [127:0] cdata  [logic [27:0]];
  bit           cdirty [logic [27:0]];
  logic [127:0] model_mem [logic [27:0]];
  logic [127:0] resp_mem  [logic [27:0]];

  function automatic logic [127:0] init_line(input logic [27:0] a);
    logic [127:0] l;
    logic [31:0]  x;
    if (a == 28'd0) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    for (int w = 0; w < 4; w++) begin
      x = {2'b00, a, 2'(w)};
      l[w*32 +: 32] = x * 32'h9E3779B1 + 32'h01234567;
    end
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  task automatic reportAndFinish();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  endtask

  task automatic timeoutFail(input string name);
    assertions++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    reportAndFinish();
  endtask

  // Predict the events of one request and update the model as if it completed.
  task automatic modelRequest(input bit wr, input logic [29:0] addr, input logic [31:0] wdata,
                              output bit hit);
    logic [27:0]  line, victim;
    logic [127:0] tmp;
    int           s, w;
    line = addr[29:2];
    s    = int'(line[1:0]);
    w    = int'(addr[1:0]);
    hit  = 1'b0;
    for (int i = 0; i < set_cnt[s]; i++) if (set_lines[s][i] == line) hit = 1'b1;
    if (hit) begin
      if (set_cnt[s] == 2 && set_lines[s][0] == line) begin
        set_lines[s][0] = set_lines[s][1];
        set_lines[s][1] = line;
      end
    end else begin
      if (set_cnt[s] == 2) begin
        victim = set_lines[s][0];
        if (cdirty[victim]) begin
          exp_q.push_back('{kind: EV_MEMWR, addr: victim, data: cdata[victim]});
          model_mem[victim] = cdata[victim];
        end
        cdata.delete(victim);
        cdirty.delete(victim);
        set_lines[s][0] = set_lines[s][1];
        set_cnt[s] = 1;
      end
      exp_q.push_back('{kind: EV_MEMRD, addr: line, data: 128'd0});
      cdata[line]  = model_mem.exists(line) ? model_mem[line] : init_line(line);
      cdirty[line] = 1'b0;
      set_lines[s][set_cnt[s]] = line;
      set_cnt[s]++;
    end
    tmp = cdata[line];
    if (wr) begin
      tmp[w*32 +: 32] = wdata;
      cdata[line]  = tmp;
      cdirty[line] = 1'b1;
    end else begin
      exp_q.push_back('{kind: EV_RDATA, addr: 28'd0, data: {96'd0, tmp[w*32 +: 32]}});
    end
  endtask

  // Called positioned at posedge+1; returns positioned at posedge+1 after the request retires.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [29:0] addr, input logic [31:0] wdata);
    bit hit;
    int stalls, start;
    modelRequest(wr, addr, wdata, hit);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wdata;
    drv_active = 1'b1;
    start      = mem_cycles;
    stalls     = 0;
    forever begin
      @(negedge clk);
      if (!proc_stall) break;
      stalls++;
      if (stalls > 100) timeoutFail("request_complete");
    end
    checkOutput("stall_cycles", stalls, hit ? 0 : 1 + (mem_cycles - start));
    @(posedge clk); #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    drv_active = 1'b0;
  endtask

  task automatic doReset();
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    drv_active = 1'b0;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    for (int s = 0; s < 4; s++) set_cnt[s] = 0;
    cdata.delete();
    cdirty.delete();
    @(negedge clk);
    checkOutput("reset_mem_read", mem_read, 1'b0);
    checkOutput("reset_mem_write", mem_write, 1'b0);
    checkOutput("reset_mem_addr", mem_addr, 28'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 128'd0);
    checkOutput("reset_proc_stall", proc_stall, 1'b0);
    checkOutput("reset_scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Start a read miss, withhold the refill, then reset in the middle of it.
  task automatic abortMiss(input logic [29:0] addr);
    bit   hit;
    ev_t  dropped;
    int   waited;
    modelRequest(1'b0, addr, 32'd0, hit);
    dropped    = exp_q.pop_back();
    hold_read  = 1'b1;
    proc_read  = 1'b1;
    proc_addr  = addr;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (mem_read) break;
      waited++;
      if (waited > 100) timeoutFail("abort_mem_read");
    end
    checkOutput("abort_dropped_kind", dropped.kind, EV_RDATA);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("abort_stall_held", proc_stall, 1'b1);
    @(posedge clk); #1;
    doReset();
    hold_read = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle_no_stall", proc_stall, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic popExpect(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, addr: 28'd0, data: 128'd0};
    if (exp_q.size() == 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL unexpected_event: actual kind %0d required no event", kind);
      return;
    end
    e = exp_q.pop_front();
    checkOutput("event_kind", kind, e.kind);
    ok = (e.kind == kind);
  endtask

  // Memory responder: random 1..4 cycle latency; refill reads withheld while hold_read is set.
  initial begin
    bit resp_pending;
    int resp_cnt;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    resp_pending = 1'b0;
    resp_cnt     = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (resp_pending && !mem_read && !mem_write) resp_pending = 1'b0;
      else if (!resp_pending && (mem_read || mem_write)) begin
        resp_pending = 1'b1;
        resp_cnt     = $urandom_range(0, 3);
      end
      if (resp_pending && !(mem_read && hold_read)) begin
        mem_cycles++;
        if (resp_cnt == 0) begin
          mem_ready = 1'b1;
          if (mem_write) resp_mem[mem_addr] = mem_wdata;
          else mem_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : init_line(mem_addr);
          resp_pending = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
    end
  end

  // Monitor: every new memory request and every completed read is matched against the scoreboard.
  initial begin
    bit  prev_rd, prev_wr, ok;
    ev_t e;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write)
        checkOutput("mem_rd_wr_exclusive", mem_read & mem_write, 1'b0);
      if (mem_write && !prev_wr) begin
        popExpect(EV_MEMWR, e, ok);
        if (ok) begin
          checkOutput("wb_addr", mem_addr, e.addr);
          checkOutput("wb_line", mem_wdata, e.data);
        end
      end
      if (mem_read && !prev_rd) begin
        popExpect(EV_MEMRD, e, ok);
        if (ok) checkOutput("refill_addr", mem_addr, e.addr);
      end
      if (drv_active && proc_read && !proc_write && !proc_stall) begin
        popExpect(EV_RDATA, e, ok);
        if (ok) checkOutput("proc_rdata", proc_rdata, e.data[31:0]);
      end
      prev_rd = mem_read;
      prev_wr = mem_write;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    failures++;
    reportAndFinish();
  end

  initial begin
    logic [25:0] tags [6];
    logic [25:0] t;
    int          r;
    tags = '{26'd0, 26'd1, 26'd2, 26'd3, 26'h2000000, 26'h2000001};
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    for (int s = 0; s < 4; s++) set_cnt[s] = 0;
    @(posedge clk); #1;
    doReset();

    $display("[TB] directed: cold miss, two tags in set 0, dirty eviction");
    applyStimulus(1'b1, 1'b0, 30'h000, 32'd0);
    applyStimulus(1'b1, 1'b0, 30'h010, 32'd0);
    applyStimulus(1'b1, 1'b0, 30'h000, 32'd0);
    applyStimulus(1'b1, 1'b0, 30'h010, 32'd0);
    applyStimulus(1'b0, 1'b1, 30'h001, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 30'h010, 32'd0);
    applyStimulus(1'b1, 1'b0, 30'h020, 32'd0);
    idleCycles(2);

    $display("[TB] directed: write miss to clean set, read+write precedence");
    applyStimulus(1'b0, 1'b1, 30'h004, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 30'h004, 32'd0);
    applyStimulus(1'b1, 1'b1, 30'h005, 32'hA5A55A5A);
    applyStimulus(1'b1, 1'b0, 30'h005, 32'd0);
    applyStimulus(1'b1, 1'b0, 30'h001, 32'd0);

    $display("[TB] directed: reset during refill");
    abortMiss(30'h030);
    applyStimulus(1'b1, 1'b0, 30'h000, 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      t = tags[$urandom_range(0, 5)];
      proc_addr = {t, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 9);
      if (r < 5)      applyStimulus(1'b1, 1'b0, proc_addr, 32'd0);
      else if (r < 9) applyStimulus(1'b0, 1'b1, proc_addr, $urandom);
      else            applyStimulus(1'b1, 1'b1, proc_addr, $urandom);
      if ($urandom_range(0, 7) == 0) idleCycles(1);
    end

    idleCycles(3);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    reportAndFinish();
  end

endmodule
